// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage sequencing controller:
// FSM encoding, drain counter width and default address constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        DRAIN   = 2'd3
    } fetch_state_e;

    localparam int          ADDR_W_DEF       = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] INT_VECTOR_DEF   = 32'h0000_0010;
    localparam int          DRAIN_CNT_W      = 3;

endpackage

// File: rtl/fetch_drain_cnt.sv
// Loadable down-counter for post-redirect bubbles; load wins over decrement.
// One-cycle update latency; decrement is held off while the caller is stalled.
module fetch_drain_cnt
    import fetch_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   load_i,
    input  logic [DRAIN_CNT_W-1:0] load_val_i,
    input  logic                   dec_i,
    output logic [DRAIN_CNT_W-1:0] cnt_o,
    output logic                   zero_o
);

    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencing: zero-cycle redirect controls, drain bubbles, IFValid one cycle later.
// Optional FETCH_PERF_EN adds saturating stall/redirect counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
    parameter logic [ADDR_W-1:0] INT_VECTOR   = ADDR_W'(INT_VECTOR_DEF),
    parameter int                DRAIN_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ExRedirect,
    input  logic [ADDR_W-1:0] ExTarget,
    input  logic              IntReq,
    output logic              IntAck,
    input  logic              PredTaken,
    input  logic              HazardStall,
    input  logic              ImemReady,
    output logic              ImemReq,
    output logic              FlushPipeandPC,
    output logic              PCStall,
    output logic              PCSource,
    output logic [ADDR_W-1:0] JmpAddr,
    output logic              IFValid,
    output logic [1:0]        FsmState
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       StallCnt,
    output logic [31:0]       RedirectCnt
`endif
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES);

    fetch_state_e           state_q, state_d;
    logic [ADDR_W-1:0]      jmp_q;
    logic                   ifvalid_q;
    logic                   cnt_load, cnt_dec, cnt_zero;
    logic [DRAIN_CNT_W-1:0] cnt;
    logic                   drain_last;

    fetch_drain_cnt u_drain_cnt (
        .clk_i      (Clk),
        .rst_n_i    (Rst_n),
        .load_i     (cnt_load),
        .load_val_i (DRAIN_LOAD),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    assign drain_last = (cnt == DRAIN_CNT_W'(1)) || cnt_zero;

    always_comb begin
        state_d        = state_q;
        FlushPipeandPC = 1'b0;
        PCStall        = 1'b0;
        PCSource       = 1'b0;
        JmpAddr        = jmp_q;
        ImemReq        = 1'b0;
        IntAck         = 1'b0;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        unique case (state_q)
            BOOT: begin
                FlushPipeandPC = 1'b1;
                JmpAddr        = RESET_VECTOR;
                cnt_load       = 1'b1;
                state_d        = DRAIN;
            end
            RUN, MEMWAIT: begin
                ImemReq = 1'b1;
                if (IntReq) begin
                    // Interrupt beats a same-cycle execute redirect; the flush kills EX too.
                    FlushPipeandPC = 1'b1;
                    JmpAddr        = INT_VECTOR;
                    IntAck         = 1'b1;
                    ImemReq        = 1'b0;
                    cnt_load       = 1'b1;
                    state_d        = DRAIN;
                end else if (ExRedirect) begin
                    FlushPipeandPC = 1'b1;
                    JmpAddr        = ExTarget;
                    ImemReq        = 1'b0;
                    cnt_load       = 1'b1;
                    state_d        = DRAIN;
                end else if (HazardStall) begin
                    PCStall = 1'b1;
                end else if (!ImemReady) begin
                    PCStall = 1'b1;
                    state_d = MEMWAIT;
                end else begin
                    PCSource = PredTaken;
                    state_d  = RUN;
                end
            end
            DRAIN: begin
                ImemReq = 1'b1;
                // Mid-drain the execute-path flush outranks a pending interrupt.
                if (ExRedirect) begin
                    FlushPipeandPC = 1'b1;
                    JmpAddr        = ExTarget;
                    cnt_load       = 1'b1;
                end else if (IntReq) begin
                    FlushPipeandPC = 1'b1;
                    JmpAddr        = INT_VECTOR;
                    IntAck         = 1'b1;
                    cnt_load       = 1'b1;
                end else begin
                    PCStall = HazardStall || !ImemReady;
                    cnt_dec = !PCStall;
                    if (drain_last && ImemReady) begin
                        state_d = RUN;
                    end
                end
            end
        endcase
        if (!Rst_n) begin
            FlushPipeandPC = 1'b0;
            PCStall        = 1'b0;
            PCSource       = 1'b0;
            JmpAddr        = RESET_VECTOR;
            ImemReq        = 1'b0;
            IntAck         = 1'b0;
            cnt_load       = 1'b0;
            cnt_dec        = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= BOOT;
            jmp_q     <= RESET_VECTOR;
            ifvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (FlushPipeandPC) begin
                jmp_q <= JmpAddr;
            end
            ifvalid_q <= ((state_q == RUN) || (state_q == MEMWAIT)) && ImemReady
                         && !HazardStall && !FlushPipeandPC;
        end
    end

    assign IFValid  = ifvalid_q && Rst_n;
    assign FsmState = Rst_n ? state_q : 2'b00;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, redir_cnt_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (PCStall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (FlushPipeandPC && (state_q != BOOT) && (redir_cnt_q != '1)) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
        end
    end

    assign StallCnt    = Rst_n ? stall_cnt_q : 32'd0;
    assign RedirectCnt = Rst_n ? redir_cnt_q : 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl with a cycle-level reference model of the fetch sequencing rules.
// Directed scenarios first, then random traffic including occasional resets.
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] IV = 32'h0000_0010;
    localparam int          DC = 2;
    localparam int P_BOOT = 0, P_RUN = 1, P_WAIT = 2, P_DRAIN = 3;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        ExRedirect = 1'b0;
    logic [31:0] ExTarget = '0;
    logic        IntReq = 1'b0;
    logic        PredTaken = 1'b0;
    logic        HazardStall = 1'b0;
    logic        ImemReady = 1'b0;
    logic        IntAck, ImemReq, FlushPipeandPC, PCStall, PCSource, IFValid;
    logic [31:0] JmpAddr;
    logic [1:0]  FsmState;
`ifdef FETCH_PERF_EN
    logic [31:0] StallCnt, RedirectCnt;
`endif

    fetch_ctrl dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .ExRedirect     (ExRedirect),
        .ExTarget       (ExTarget),
        .IntReq         (IntReq),
        .IntAck         (IntAck),
        .PredTaken      (PredTaken),
        .HazardStall    (HazardStall),
        .ImemReady      (ImemReady),
        .ImemReq        (ImemReq),
        .FlushPipeandPC (FlushPipeandPC),
        .PCStall        (PCStall),
        .PCSource       (PCSource),
        .JmpAddr        (JmpAddr),
        .IFValid        (IFValid),
        .FsmState       (FsmState)
`ifdef FETCH_PERF_EN
        ,
        .StallCnt       (StallCnt),
        .RedirectCnt    (RedirectCnt)
`endif
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase as the documented state code, bubbles still owed, last redirect target.
    int          m_phase = P_BOOT;
    int          m_left  = 0;
    logic [31:0] m_jmp   = RV;
    logic        m_ifv   = 1'b0;
    longint      m_stall_cnt = 0;
    longint      m_redir_cnt = 0;

    task automatic step(input logic rst, input logic ex, input logic [31:0] tgt,
                        input logic irq, input logic pred, input logic hz, input logic rdy);
        logic        e_fl, e_st, e_src, e_req, e_ack;
        logic [31:0] e_j;
        int          nph, nleft;
        @(negedge Clk);
        Rst_n = rst; ExRedirect = ex; ExTarget = tgt; IntReq = irq;
        PredTaken = pred; HazardStall = hz; ImemReady = rdy;
        #1;
        e_fl = 0; e_st = 0; e_src = 0; e_req = 0; e_ack = 0;
        e_j = m_jmp; nph = m_phase; nleft = m_left;
        if (!rst) begin
            e_j = RV; nph = P_BOOT; nleft = 0;
        end else if (m_phase == P_BOOT) begin
            e_fl = 1; e_j = RV; nph = P_DRAIN; nleft = DC;
        end else if (m_phase == P_RUN || m_phase == P_WAIT) begin
            e_req = 1;
            if (irq) begin
                e_fl = 1; e_j = IV; e_ack = 1; e_req = 0; nph = P_DRAIN; nleft = DC;
            end else if (ex) begin
                e_fl = 1; e_j = tgt; e_req = 0; nph = P_DRAIN; nleft = DC;
            end else if (hz) begin
                e_st = 1;
            end else if (!rdy) begin
                e_st = 1; nph = P_WAIT;
            end else begin
                e_src = pred; nph = P_RUN;
            end
        end else begin
            e_req = 1;
            if (ex) begin
                e_fl = 1; e_j = tgt; nleft = DC;
            end else if (irq) begin
                e_fl = 1; e_j = IV; e_ack = 1; nleft = DC;
            end else begin
                e_st = hz || !rdy;
                if (m_left <= 1 && rdy) nph = P_RUN;
                else if (!e_st && m_left > 0) nleft = m_left - 1;
            end
        end
        chk("flush",    FlushPipeandPC, e_fl);
        chk("pcstall",  PCStall,        e_st);
        chk("pcsource", PCSource,       e_src);
        chk("jmpaddr",  JmpAddr,        e_j);
        chk("imemreq",  ImemReq,        e_req);
        chk("intack",   IntAck,         e_ack);
        chk("fsmstate", FsmState,       rst ? 64'(m_phase) : 64'd0);
        chk("ifvalid",  IFValid,        rst ? m_ifv : 1'b0);
`ifdef FETCH_PERF_EN
        chk("stallcnt", StallCnt,       rst ? 64'(m_stall_cnt) : 64'd0);
        chk("redircnt", RedirectCnt,    rst ? 64'(m_redir_cnt) : 64'd0);
`endif
        m_ifv = rst && (m_phase == P_RUN || m_phase == P_WAIT) && rdy && !hz && !e_fl;
        if (e_fl) m_jmp = e_j;
        if (!rst) begin
            m_jmp = RV; m_stall_cnt = 0; m_redir_cnt = 0;
        end else begin
            if (e_st && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
            if (e_fl && m_phase != P_BOOT && m_redir_cnt < 64'hFFFF_FFFF) m_redir_cnt++;
        end
        m_phase = nph;
        m_left  = nleft;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 32'h0, 0, 0, 0, 1);
    endtask

    initial begin
        // Reset held three cycles, then boot and drain.
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 0, 0, 1);
        step(1, 0, 32'h0, 0, 0, 0, 1);
        chk("boot_state", FsmState, 2'd0);
        chk("boot_flush", FlushPipeandPC, 1'b1);
        chk("boot_jmp", JmpAddr, RV);
        idle(3);
        step(1, 0, 32'h0, 0, 0, 0, 1);
        chk("run_ifvalid", IFValid, 1'b1);

        // Execute redirect.
        step(1, 1, 32'h0000_0200, 0, 0, 0, 1);
        chk("redir_jmp", JmpAddr, 32'h0000_0200);
        chk("redir_flush", FlushPipeandPC, 1'b1);
        idle(3);

        // Interrupt collides with execute redirect.
        step(1, 1, 32'h0000_0300, 1, 0, 0, 1);
        chk("int_jmp", JmpAddr, 32'h0000_0010);
        chk("int_ack", IntAck, 1'b1);
        step(1, 0, 32'h0, 0, 0, 0, 1);
        chk("int_ack_pulse", IntAck, 1'b0);
        idle(2);

        // Instruction memory wait.
        step(1, 0, 32'h0, 0, 0, 0, 0);
        step(1, 0, 32'h0, 0, 0, 0, 0);
        chk("memwait_state", FsmState, 2'd2);
        chk("memwait_stall", PCStall, 1'b1);
        step(1, 0, 32'h0, 0, 0, 0, 0);
        step(1, 0, 32'h0, 0, 0, 0, 0);
        step(1, 0, 32'h0, 0, 0, 0, 1);

        // Hazard stall beats prediction.
        step(1, 0, 32'h0, 0, 1, 1, 1);
        chk("hz_stall", PCStall, 1'b1);
        chk("hz_nosrc", PCSource, 1'b0);
        step(1, 0, 32'h0, 0, 1, 0, 1);
        chk("pred_src", PCSource, 1'b1);

        // Reset while one bubble is still owed.
        step(1, 1, 32'h0000_0040, 0, 0, 0, 1);
        step(1, 0, 32'h0, 0, 0, 0, 1);
        step(0, 0, 32'h0, 0, 0, 0, 1);
        step(1, 0, 32'h0, 0, 0, 0, 1);
        chk("rst_drain_state", FsmState, 2'd0);
`ifdef FETCH_PERF_EN
        chk("rst_stallcnt", StallCnt, 32'd0);
        chk("rst_redircnt", RedirectCnt, 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_ex, r_irq, r_pred, r_hz, r_rdy;
            r_rst  = ($urandom_range(0, 199) != 0);
            r_ex   = ($urandom_range(0, 11) == 0);
            r_irq  = ($urandom_range(0, 19) == 0);
            r_pred = ($urandom_range(0, 2) == 0);
            r_hz   = ($urandom_range(0, 5) == 0);
            r_rdy  = ($urandom_range(0, 4) != 0);
            step(r_rst, r_ex, $urandom, r_irq, r_pred, r_hz, r_rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
